// File: rtl/npu_pkg.sv
//==============================================================================
// Module      : npu_pkg
// Description : Shared NPU definitions: conv result geometry, pooling state
//               encoding, and signed helper functions used by the pooling
//               stage.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package npu_pkg;

    // Geometry of the conv_engine_2d result stream.
    localparam int CONV_OUT_W   = 22;
    localparam int CONV_OUT_DIM = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_t;

    // Signed maximum; on a tie both operands are equal, so either is correct.
    function automatic logic signed [CONV_OUT_W-1:0] smax(
        input logic signed [CONV_OUT_W-1:0] a,
        input logic signed [CONV_OUT_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Clamp negative values to zero.
    function automatic logic signed [CONV_OUT_W-1:0] relu(
        input logic signed [CONV_OUT_W-1:0] x
    );
        return x[CONV_OUT_W-1] ? '0 : x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pool_row_buffer.sv
//==============================================================================
// Module      : pool_row_buffer
// Description : Half-row store of horizontal-pair maxima for the 2x2 pooling
//               window. One synchronous write port, one combinational read
//               port; no reset on the storage so it maps to distributed RAM.
// Ports       : clk       - clock
//               i_wr_en   - write enable
//               i_wr_addr - write index (col/2)
//               i_wr_data - pair maximum to store
//               i_rd_addr - read index (col/2)
//               o_rd_data - stored pair maximum at i_rd_addr
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pool_row_buffer #(
    parameter int DEPTH  = 15,
    parameter int DATA_W = 22,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic signed [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]        i_rd_addr,
    output logic signed [DATA_W-1:0] o_rd_data
);

    logic signed [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/maxpool_2x2_stage.sv
//==============================================================================
// Module      : maxpool_2x2_stage
// Description : Streaming 2x2 / stride-2 signed max-pooling of the row-major
//               conv result stream. Even rows park horizontal-pair maxima in a
//               half-row buffer; odd rows combine them with their own pair and
//               emit one pooled sample per 2x2 window, one cycle after the
//               window's bottom-right sample.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start_signal  - arms (or restarts) a frame
//               conv_in       - signed input sample, valid with conv_valid
//               pool_out      - signed pooled maximum, valid with pool_valid
//               done_signal   - one-cycle pulse after the last pooled output
//               busy          - high while in RUN or DONE
// Options     : POOL_RELU_EN  - when defined, samples are clamped at zero
//                               before comparison (pool_out >= 0).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module maxpool_2x2_stage
    import npu_pkg::*;
#(
    parameter int IMG_W  = CONV_OUT_DIM,
    parameter int IMG_H  = CONV_OUT_DIM,
    parameter int DATA_W = CONV_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_signal,
    input  logic signed [DATA_W-1:0] conv_in,
    input  logic                     conv_valid,
    output logic signed [DATA_W-1:0] pool_out,
    output logic                     pool_valid,
    output logic                     done_signal,
    output logic                     busy
);

    localparam int c_COL_W  = $clog2(IMG_W);
    localparam int c_ROW_W  = $clog2(IMG_H);
    localparam int c_ADDR_W = c_COL_W - 1;

    pool_state_t r_state;
    pool_state_t w_state_nxt;

    logic [c_COL_W-1:0]       r_col;
    logic [c_ROW_W-1:0]       r_row;
    logic signed [DATA_W-1:0] r_h;
    logic signed [DATA_W-1:0] r_pool_out;
    logic                     r_pool_valid;
    logic                     r_done;

    logic                     w_accept;
    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_frame_last;
    logic                     w_lb_we;
    logic                     w_emit;
    logic signed [DATA_W-1:0] w_sample;
    logic signed [DATA_W-1:0] w_lb_rd;
    logic signed [DATA_W-1:0] w_pair_max;
    logic signed [DATA_W-1:0] w_win_max;

    // A start in the same cycle as conv_valid takes priority: the sample is
    // dropped and the frame begins with the next valid cycle.
    assign w_accept     = (r_state == RUN) && conv_valid && !start_signal;
    assign w_col_last   = (r_col == c_COL_W'(IMG_W - 1));
    assign w_row_last   = (r_row == c_ROW_W'(IMG_H - 1));
    assign w_frame_last = w_accept && w_col_last && w_row_last;
    assign w_lb_we      = w_accept && !r_row[0] && r_col[0];
    assign w_emit       = w_accept &&  r_row[0] && r_col[0];

`ifdef POOL_RELU_EN
    assign w_sample = relu(conv_in);
`else
    assign w_sample = conv_in;
`endif

    // r_h holds the even-column sample of the current row, so at an odd column
    // w_pair_max is the horizontal pair maximum for either row parity.
    assign w_pair_max = smax(r_h, w_sample);
    assign w_win_max  = smax(w_lb_rd, w_pair_max);

    pool_row_buffer #(
        .DEPTH  (IMG_W / 2),
        .DATA_W (DATA_W),
        .ADDR_W (c_ADDR_W)
    ) u_row_buffer (
        .clk       (clk),
        .i_wr_en   (w_lb_we),
        .i_wr_addr (r_col[c_COL_W-1:1]),
        .i_wr_data (w_pair_max),
        .i_rd_addr (r_col[c_COL_W-1:1]),
        .o_rd_data (w_lb_rd)
    );

    //--------------------------------------------------------------------------
    // State machine
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start_signal) w_state_nxt = RUN;
            RUN: begin
                if (start_signal)      w_state_nxt = RUN;
                else if (w_frame_last) w_state_nxt = DONE;
            end
            DONE: w_state_nxt = start_signal ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Position counters
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || start_signal) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + c_ROW_W'(1);
            end else begin
                r_col <= r_col + c_COL_W'(1);
            end
        end
    end

    // Even-column holding register; contents are don't-care out of RUN.
    always_ff @(posedge clk) begin
        if (w_accept && !r_col[0]) begin
            r_h <= w_sample;
        end
    end

    //--------------------------------------------------------------------------
    // Output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pool_out   <= '0;
            r_pool_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_pool_valid <= w_emit;
            if (w_emit) begin
                r_pool_out <= w_win_max;
            end
            // DONE lasts one cycle (the final pool_valid); the pulse follows it
            // unless a restart arrives in that cycle.
            r_done <= (r_state == DONE) && !start_signal;
        end
    end

    assign pool_out    = r_pool_out;
    assign pool_valid  = r_pool_valid;
    assign done_signal = r_done;
    assign busy        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_maxpool_2x2_stage.sv
`timescale 1ns/1ps
`default_nettype none

module tb_maxpool_2x2_stage;

    localparam int IMG_W  = 30;
    localparam int IMG_H  = 30;
    localparam int DATA_W = 22;
    localparam int N_IN   = IMG_W * IMG_H;
    localparam int N_OUT  = (IMG_W / 2) * (IMG_H / 2);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start_signal = 1'b0;
    logic signed [DATA_W-1:0] conv_in = '0;
    logic                     conv_valid = 1'b0;
    logic signed [DATA_W-1:0] pool_out;
    logic                     pool_valid;
    logic                     done_signal;
    logic                     busy;

    maxpool_2x2_stage #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_signal (start_signal),
        .conv_in      (conv_in),
        .conv_valid   (conv_valid),
        .pool_out     (pool_out),
        .pool_valid   (pool_valid),
        .done_signal  (done_signal),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Output monitor
    int outq[$];
    int done_cnt = 0;
    int overlap_cnt = 0;
    int last_valid_cyc = -1;
    int done_cyc = -1;

    always @(negedge clk) begin
        if (pool_valid) begin
            outq.push_back(int'(pool_out));
            last_valid_cyc = cyc;
        end
        if (done_signal) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (pool_valid && done_signal) overlap_cnt++;
    end

    // Stimulus patterns: 0 ramp, 1 vertical edge, 2 constant -1020.
    function automatic int sample_val(input int mode, input int idx);
        int r = idx / IMG_W;
        int c = idx % IMG_W;
        case (mode)
            0:       return r * 30 + c;
            1:       return (c == 14 || c == 15) ? 1020 : 0;
            default: return -1020;
        endcase
    endfunction

    // Hand-derived pooled values for pooled position k (row-major, 15 wide).
    function automatic int exp_val(input int mode, input int k);
        int i = k / (IMG_W / 2);
        int j = k % (IMG_W / 2);
        case (mode)
            0:       return (2 * i + 1) * 30 + 2 * j + 1;
            1:       return (j == 7) ? 1020 : 0;
`ifdef POOL_RELU_EN
            default: return 0;
`else
            default: return -1020;
`endif
        endcase
    endfunction

    task automatic clear_mon();
        outq.delete();
        done_cnt       = 0;
        overlap_cnt    = 0;
        last_valid_cyc = -1;
        done_cyc       = -1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_signal = 1'b1;
        conv_valid   = 1'b0;
        @(negedge clk);
        start_signal = 1'b0;
    endtask

    task automatic drive_samples(input int mode, input int gap, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            conv_valid = 1'b1;
            conv_in    = DATA_W'(sample_val(mode, first + k));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                conv_valid = 1'b0;
                conv_in    = DATA_W'(12345);
            end
        end
        @(negedge clk);
        conv_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        conv_valid = 1'b1;
        conv_in    = DATA_W'(777);
        repeat (3) @(negedge clk);
        n_checks++;
        if (pool_out !== '0) begin n_fail++; $display("FAIL reset_pool_out: got %0d want 0", pool_out); end
        n_checks++;
        if (pool_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pool_valid: got %b want 0", pool_valid); end
        n_checks++;
        if (done_signal !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_signal); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        clear_mon();
        // conv_valid in IDLE without a start must do nothing
        repeat (12) @(negedge clk);
        conv_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outq.size() != 0 || done_cnt != 0) begin
            n_fail++; $display("FAIL idle_ignore: outputs %0d done %0d want 0 0", outq.size(), done_cnt);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_frame(input int mode, input int gap, input string name);
        clear_mon();
        pulse_start();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_run: got %b want 1", name, busy); end
        drive_samples(mode, gap, 0, N_IN);
        wait_done();
        n_checks++;
        if (outq.size() != N_OUT) begin
            n_fail++; $display("FAIL %s_count: got %0d want %0d", name, outq.size(), N_OUT);
        end
        for (int k = 0; k < outq.size() && k < N_OUT; k++) begin
            n_checks++;
            if (outq[k] != exp_val(mode, k)) begin
                n_fail++; $display("FAIL %s_value[%0d]: got %0d want %0d", name, k, outq[k], exp_val(mode, k));
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt); end
        n_checks++;
        if (done_cyc != last_valid_cyc + 1) begin
            n_fail++; $display("FAIL %s_done_timing: done at %0d want %0d", name, done_cyc, last_valid_cyc + 1);
        end
        n_checks++;
        if (overlap_cnt != 0) begin n_fail++; $display("FAIL %s_overlap: got %0d want 0", name, overlap_cnt); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end: got %b want 0", name, busy); end
    endtask

    task automatic test_post_frame_ignore();
        clear_mon();
        drive_samples(0, 0, 0, 20);
        repeat (3) @(negedge clk);
        n_checks++;
        if (outq.size() != 0 || done_cnt != 0) begin
            n_fail++; $display("FAIL post_frame_ignore: outputs %0d done %0d want 0 0", outq.size(), done_cnt);
        end
    endtask

    task automatic test_rst_mid();
        clear_mon();
        pulse_start();
        drive_samples(0, 0, 0, 400);
        @(negedge clk);
        // 400 samples: pooled rows 0..5 (90) plus 5 windows of pooled row 6
        n_checks++;
        if (outq.size() != 95) begin n_fail++; $display("FAIL rst_mid_partial: got %0d want 95", outq.size()); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (pool_out !== '0 || pool_valid !== 1'b0 || done_signal !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got out=%0d v=%b d=%b want 0 0 0", pool_out, pool_valid, done_signal);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        drive_samples(0, 0, 0, 60);
        repeat (3) @(negedge clk);
        n_checks++;
        if (outq.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_needs_start: outputs %0d busy %b want 0 0", outq.size(), busy);
        end
        test_frame(0, 0, "post_rst_ramp");
    endtask

    task automatic test_abort();
        clear_mon();
        pulse_start();
        drive_samples(0, 0, 0, 99);
        // Restart together with a window-completing sample; that sample must be dropped.
        @(negedge clk);
        start_signal = 1'b1;
        conv_valid   = 1'b1;
        conv_in      = DATA_W'(sample_val(0, 99));
        @(negedge clk);
        start_signal = 1'b0;
        conv_valid   = 1'b0;
        drive_samples(0, 0, 0, N_IN);
        wait_done();
        // 99 aborted samples yield 15 + 4 windows before the restart
        n_checks++;
        if (outq.size() != 19 + N_OUT) begin
            n_fail++; $display("FAIL abort_count: got %0d want %0d", outq.size(), 19 + N_OUT);
        end
        for (int k = 0; k < outq.size() && k < 19 + N_OUT; k++) begin
            int e = (k < 19) ? exp_val(0, k) : exp_val(0, k - 19);
            n_checks++;
            if (outq[k] != e) begin
                n_fail++; $display("FAIL abort_value[%0d]: got %0d want %0d", k, outq[k], e);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL abort_done_count: got %0d want 1", done_cnt); end
        n_checks++;
        if (overlap_cnt != 0) begin n_fail++; $display("FAIL abort_overlap: got %0d want 0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_frame(0, 0, "ramp");
        test_post_frame_ignore();
        test_frame(1, 0, "edge");
        test_frame(2, 0, "const");
        test_frame(0, 2, "gapped");
        test_rst_mid();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
